screen_message_mux: RTL and testbench



---
 rtl/screen_message_mux.sv | 161 ++++++++++++++++
 tb/tb_screen_message_mux.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/screen_message_mux.sv
// screen_message_mux: frame-synchronous full-screen message selector.
// Picks the highest-priority active message layer, switches only at frame
// boundaries with optional blank frames in between, and supports blinking.
module screen_message_mux #(
  parameter int                 NUM_MSG      = 4,
  parameter int                 RGB_W        = 8,
  parameter logic [RGB_W-1:0]   TRANSPARENT  = '0,
  parameter int                 BLANK_FRAMES = 8,
  parameter int                 BLINK_FRAMES = 16,
  localparam int                IDX_W        = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic [NUM_MSG-1:0]       msgActive,
  input  logic [NUM_MSG-1:0]       msgDrawingRequest,
  input  logic [NUM_MSG*RGB_W-1:0] msgRGB,
  input  logic [NUM_MSG-1:0]       blinkEn,
  output logic                     DrawingRequest,
  output logic [RGB_W-1:0]         RGBOut,
  output logic [IDX_W-1:0]         activeIdx,
  output logic                     messageShown
);

  localparam int BCNT_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCNT_W-1:0] BLANK_LOAD = BCNT_W'(BLANK_FRAMES);
  localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   sel, sel_next;
  logic [BCNT_W-1:0]  blank_cnt, blank_next;
  logic [FCNT_W-1:0]  frame_cnt, frame_next;
  logic               blink_phase, phase_next;

  logic [IDX_W-1:0]   cand;
  logic               cand_valid;
  logic [RGB_W-1:0]   sel_rgb;
  logic               sel_req;
  logic               sel_blink;
  logic               visible;

  // Priority encoder: lowest active index wins
  always_comb begin
    cand       = '0;
    cand_valid = |msgActive;
    for (int i = NUM_MSG - 1; i >= 0; i--) begin
      if (msgActive[i]) cand = IDX_W'(i);
    end
  end

  // Pick out the currently selected channel's request, colour and blink enable
  always_comb begin
    sel_rgb   = TRANSPARENT;
    sel_req   = 1'b0;
    sel_blink = 1'b0;
    for (int i = 0; i < NUM_MSG; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_rgb   = msgRGB[i*RGB_W +: RGB_W];
        sel_req   = msgDrawingRequest[i];
        sel_blink = blinkEn[i];
      end
    end
  end

  // State and frame counters, only ever updated on a frame boundary
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      sel         <= '0;
      blank_cnt   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_next;
      sel         <= sel_next;
      blank_cnt   <= blank_next;
      frame_cnt   <= frame_next;
      blink_phase <= phase_next;
    end
  end

  // Next-state logic: arbitration, blank insertion and blink counting
  always_comb begin
    state_next = state;
    sel_next   = sel;
    blank_next = blank_cnt;
    frame_next = frame_cnt;
    phase_next = blink_phase;
    if (startOfFrame) begin
      case (state)
        IDLE: begin
          if (cand_valid) begin
            if (BLANK_FRAMES == 0) begin
              state_next = SHOW;
              sel_next   = cand;
              frame_next = '0;
              phase_next = 1'b0;
            end else begin
              state_next = BLANK;
              blank_next = BLANK_LOAD;
            end
          end
        end
        SHOW: begin
          if (!cand_valid || cand != sel) begin
            if (BLANK_FRAMES == 0) begin
              if (cand_valid) begin
                sel_next   = cand;
                frame_next = '0;
                phase_next = 1'b0;
              end else begin
                state_next = IDLE;
              end
            end else begin
              state_next = BLANK;
              blank_next = BLANK_LOAD;
            end
          end else if (frame_cnt == FRAME_LAST) begin
            frame_next = '0;
            phase_next = ~blink_phase;
          end else begin
            frame_next = frame_cnt + 1'b1;
          end
        end
        BLANK: begin
          blank_next = blank_cnt - 1'b1;
          if (blank_cnt == BCNT_W'(1)) begin
            if (cand_valid) begin
              state_next = SHOW;
              sel_next   = cand;
              frame_next = '0;
              phase_next = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign visible = (state == SHOW) && !(sel_blink && blink_phase);

  // Registered output pixel: selected colour where the message draws, else transparent
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBOut <= TRANSPARENT;
    end else begin
      RGBOut <= (visible && sel_req) ? sel_rgb : TRANSPARENT;
    end
  end

  assign DrawingRequest = (RGBOut != TRANSPARENT);
  assign activeIdx      = (state == SHOW) ? sel : '0;
  assign messageShown   = (state == SHOW);

endmodule

// File: tb/tb_screen_message_mux.sv
// Testbench for screen_message_mux: two instances (blank=2/blink=3 and
// blank=0/blink=1) share random stimulus and are compared every cycle
// against a frame-level reference model.
module tb_screen_message_mux;

  localparam int FRAME = 8;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [3:0]  msgActive;
  logic [3:0]  msgDrawingRequest;
  logic [31:0] msgRGB;
  logic [3:0]  blinkEn;

  logic        dr_a, dr_b, shown_a, shown_b;
  logic [7:0]  rgb_a, rgb_b;
  logic [1:0]  idx_a, idx_b;

  int tests = 0;
  int fails = 0;
  int pos = 0;
  int force_zero_ch = -1;

  // Reference model per instance: shown channel (-1 none), blank frames
  // remaining, and frames elapsed since the message appeared
  int m_shown[2];
  int m_blank[2];
  int m_frames[2];
  int blank_of[2] = '{2, 0};
  int blink_of[2] = '{3, 1};

  screen_message_mux #(.NUM_MSG(4), .RGB_W(8), .TRANSPARENT(8'h00),
                       .BLANK_FRAMES(2), .BLINK_FRAMES(3)) dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .msgActive(msgActive), .msgDrawingRequest(msgDrawingRequest),
    .msgRGB(msgRGB), .blinkEn(blinkEn),
    .DrawingRequest(dr_a), .RGBOut(rgb_a), .activeIdx(idx_a),
    .messageShown(shown_a));

  screen_message_mux #(.NUM_MSG(4), .RGB_W(8), .TRANSPARENT(8'h00),
                       .BLANK_FRAMES(0), .BLINK_FRAMES(1)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .msgActive(msgActive), .msgDrawingRequest(msgDrawingRequest),
    .msgRGB(msgRGB), .blinkEn(blinkEn),
    .DrawingRequest(dr_b), .RGBOut(rgb_b), .activeIdx(idx_b),
    .messageShown(shown_b));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int candidate(input logic [3:0] act);
    for (int i = 0; i < 4; i++) if (act[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_shown[d]  = -1;
      m_blank[d]  = 0;
      m_frames[d] = 0;
    end
  endtask

  task automatic check_dut(input int d, input logic [7:0] e_rgb, input logic [1:0] e_idx, input logic e_shown);
    logic [7:0] o_rgb;
    logic [1:0] o_idx;
    logic       o_dr, o_shown;
    o_rgb   = (d == 0) ? rgb_a : rgb_b;
    o_idx   = (d == 0) ? idx_a : idx_b;
    o_dr    = (d == 0) ? dr_a : dr_b;
    o_shown = (d == 0) ? shown_a : shown_b;
    checkOutput($sformatf("rgb%0d", d), 32'(o_rgb), 32'(e_rgb));
    checkOutput($sformatf("drawreq%0d", d), 32'(o_dr), 32'(e_rgb != 8'h00));
    checkOutput($sformatf("idx%0d", d), 32'(o_idx), 32'(e_idx));
    checkOutput($sformatf("shown%0d", d), 32'(o_shown), 32'(e_shown));
  endtask

  // One pixel clock: drive random pixel data, advance model, check both DUTs
  task automatic applyStimulus();
    logic [7:0] e_rgb[2];
    logic [1:0] e_idx[2];
    logic       e_shown[2];
    logic       vis;
    int         c;
    startOfFrame      = (pos == 0);
    msgDrawingRequest = 4'($urandom);
    for (int i = 0; i < 4; i++)
      msgRGB[i*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    if (force_zero_ch >= 0) begin
      msgRGB[force_zero_ch*8 +: 8]     = 8'h00;
      msgDrawingRequest[force_zero_ch] = 1'b1;
    end
    @(posedge clk);
    c = candidate(msgActive);
    for (int d = 0; d < 2; d++) begin
      vis = (m_shown[d] >= 0) && (m_blank[d] == 0) &&
            !(blinkEn[m_shown[d]] && ((m_frames[d] / blink_of[d]) % 2 == 1));
      e_rgb[d] = (vis && msgDrawingRequest[m_shown[d]]) ? msgRGB[m_shown[d]*8 +: 8] : 8'h00;
      if (startOfFrame) begin
        if (m_blank[d] > 0) begin
          m_blank[d]--;
          if (m_blank[d] == 0) begin
            m_shown[d]  = c;
            m_frames[d] = 0;
          end
        end else if (m_shown[d] != c) begin
          if (blank_of[d] == 0) begin
            m_shown[d]  = c;
            m_frames[d] = 0;
          end else begin
            m_shown[d] = c;
            m_blank[d] = blank_of[d];
          end
        end else if (m_shown[d] >= 0) begin
          m_frames[d]++;
        end
      end
      e_shown[d] = (m_shown[d] >= 0) && (m_blank[d] == 0);
      e_idx[d]   = e_shown[d] ? 2'(m_shown[d]) : 2'd0;
    end
    #1;
    for (int d = 0; d < 2; d++) check_dut(d, e_rgb[d], e_idx[d], e_shown[d]);
    pos = (pos + 1) % FRAME;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  task automatic run_frames(input int n);
    run_cycles(n * FRAME);
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic do_reset();
    #2 resetN = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) check_dut(d, 8'h00, 2'd0, 1'b0);
    @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  initial begin
    resetN            = 1'b0;
    startOfFrame      = 1'b0;
    msgActive         = 4'b0000;
    msgDrawingRequest = 4'b0000;
    msgRGB            = '0;
    blinkEn           = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_dut(d, 8'h00, 2'd0, 1'b0);
    resetN = 1'b1;

    // Idle with nothing active, reset mid-stream, idle again
    run_frames(1);
    run_cycles(3);
    do_reset();
    run_cycles(FRAME - 3);
    run_frames(3);

    // Enter SHOW on channel 2
    msgActive = 4'b0100;
    run_frames(5);

    // Raise channel 0 mid-frame: switch only at next frame start
    run_cycles(3);
    msgActive = 4'b0101;
    run_cycles(FRAME - 3);
    run_frames(5);

    // Blink on channel 1, then steady
    msgActive = 4'b0010;
    blinkEn   = 4'b0010;
    run_frames(14);
    blinkEn   = 4'b0000;
    run_frames(6);

    // Drop all requests while blanking
    msgActive = 4'b0001;
    run_frames(1);
    msgActive = 4'b0000;
    run_frames(4);

    // Re-raise the old channel during blanking
    msgActive = 4'b0100;
    run_frames(4);
    msgActive = 4'b0001;
    run_frames(1);
    msgActive = 4'b0100;
    run_frames(4);

    // Shown pixel whose colour equals the transparent value
    force_zero_ch = 2;
    run_frames(2);
    force_zero_ch = -1;

    // Direct switch 3 -> 1 (immediate on the zero-blank instance)
    msgActive = 4'b1000;
    run_frames(4);
    msgActive = 4'b0010;
    run_frames(4);

    // Random activity with changes at arbitrary pixels, one mid-run reset
    for (int k = 0; k < 40; k++) begin
      run_cycles($urandom_range(1, 20));
      msgActive = 4'($urandom);
      blinkEn   = 4'($urandom);
      if (k == 20) do_reset();
    end
    run_frames(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
